// File: rtl/lock_regfile_if.sv
// Bus between issue/writeback stages and lock_regfile: write, reservation and read ports.
// The master side is the pipeline and the slave side is the register file.
interface lock_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                     write_en;
    logic [ADDR_W-1:0]        write_addr;
    logic [DATA_W-1:0]        write_val;
    logic [NUM_RD-1:0]        read_en;
    logic [NUM_RD*ADDR_W-1:0] read_addr;
    logic [NUM_RD*DATA_W-1:0] read_out;
    logic [NUM_RD-1:0]        read_valid;
    logic                     res_en;
    logic [ADDR_W-1:0]        res_addr;
    logic                     res_ok;
    logic [ADDR_W:0]          pend_cnt;

    modport master (
        output write_en, write_addr, write_val, read_en, read_addr, res_en, res_addr,
        input  read_out, read_valid, res_ok, pend_cnt
    );

    modport slave (
        input  write_en, write_addr, write_val, read_en, read_addr, res_en, res_addr,
        output read_out, read_valid, res_ok, pend_cnt
    );
endinterface

// File: rtl/lock_regfile.sv
// Multi-port register file with per-register reservation locks and a hard-wired zero register.
// Optional macro LOCK_REGFILE_BYPASS_EN forwards a same-cycle write to a read of that address.
module lock_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    lock_regfile_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CW    = ADDR_W + 1;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pending_wr;
    logic [DEPTH-1:0]  pending_nxt;
    logic [CW-1:0]     pend_cnt_q;
    logic              wr_hit;
    logic              res_ok;
    logic              grant;
    logic              set_new;
    logic              clr_old;

    logic [DATA_W-1:0] rd_data [NUM_RD];
    logic [NUM_RD-1:0] rd_busy;
    logic [NUM_RD*DATA_W-1:0] rd_out_q;
    logic [NUM_RD-1:0] rd_valid_q;

    // Write clears the lock first, then a grant may take it again in the same cycle.
    always_comb begin
        wr_hit      = bus.write_en && (bus.write_addr != '0);
        res_ok      = !pending[bus.res_addr]
                    || (bus.write_en && (bus.write_addr == bus.res_addr))
                    || (bus.res_addr == '0);
        grant       = bus.res_en && res_ok && (bus.res_addr != '0);
        pending_wr  = pending;
        if (wr_hit) pending_wr[bus.write_addr] = 1'b0;
        pending_nxt = pending_wr;
        if (grant) pending_nxt[bus.res_addr] = 1'b1;
        clr_old     = wr_hit && pending[bus.write_addr];
        set_new     = grant && !pending_wr[bus.res_addr];
    end

    // Read handshake: read_en[i] in cycle T yields read_valid[i]/read_out[i] in T+1;
    // read_valid[i]=0 with read_en[i]=1 means the register is locked and must be re-read.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            logic [ADDR_W-1:0] a;
            a = bus.read_addr[p*ADDR_W +: ADDR_W];
`ifdef LOCK_REGFILE_BYPASS_EN
            rd_data[p] = (wr_hit && (bus.write_addr == a)) ? bus.write_val : regs[a];
            rd_busy[p] = pending_wr[a];
`else
            rd_data[p] = regs[a];
            rd_busy[p] = pending[a];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            pending    <= '0;
            pend_cnt_q <= '0;
            rd_out_q   <= '0;
            rd_valid_q <= '0;
        end else begin
            if (wr_hit) regs[bus.write_addr] <= bus.write_val;
            pending    <= pending_nxt;
            pend_cnt_q <= pend_cnt_q + CW'(set_new) - CW'(clr_old);
            for (int p = 0; p < NUM_RD; p++) begin
                rd_valid_q[p] <= bus.read_en[p] && !rd_busy[p];
                if (bus.read_en[p]) rd_out_q[p*DATA_W +: DATA_W] <= rd_data[p];
            end
        end
    end

    assign bus.res_ok     = res_ok;
    assign bus.pend_cnt   = pend_cnt_q;
    assign bus.read_out   = rd_out_q;
    assign bus.read_valid = rd_valid_q;
endmodule

// File: doc/lock_regfile.md
Name: lock_regfile

Overview:
- Parametrised successor to the 2-read/1-write register file used by the pipelines.
- Adds N synchronous read ports, a per-register reservation (scoreboard) lock for writes still in flight, a pending-count output, and a hard-wired zero register.
- Sits between the decode/issue stage, which reserves destinations and reads operands, and the writeback stage, which writes and releases them.

Parameters:
- DATA_W, 32, data width of each register
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  asynchronous active-low reset
- write_en  in  1  write strobe
- write_addr  in  ADDR_W  write register index
- write_val  in  DATA_W  write data
- read_en  in  NUM_RD  per-port read strobe
- read_addr  in  NUM_RD*ADDR_W  port i address at bits [i*ADDR_W +: ADDR_W]
- read_out  out  NUM_RD*DATA_W  port i data at bits [i*DATA_W +: DATA_W]; registered
- read_valid  out  NUM_RD  per-port data valid; registered
- res_en  in  1  reservation request
- res_addr  in  ADDR_W  register index to reserve
- res_ok  out  1  combinational; the reservation is grantable this cycle
- pend_cnt  out  ADDR_W+1  number of registers currently reserved

Behaviour:
- Reset (asynchronous, rst_n=0):
  - all registers, pending bits, read_out, read_valid and pend_cnt go to 0.
  - Reset asserted mid-operation discards all in-flight reads and reservations.
- Register 0:
  - always reads 0 and is never pending.
  - Writes to it are ignored.
  - A reservation of it is always granted with no side effect.
- Write: write_en=1 with write_addr!=0 updates the register at the edge and clears its pending bit.
  - Writing a non-pending register is legal: the data updates and pending stays 0.
- Reservation:
  - res_ok = !pending[res_addr] | (write_en & write_addr==res_addr) | (res_addr==0).
  - A grant (res_en & res_ok) sets pending[res_addr] at the edge.
  - A denied request changes nothing; the requester retries.
- Same-cycle write and grant to the same address: the pending bit ends at 1, meaning the old lock is released and the new one is taken.
- Read:
  - Latency is 1 cycle. Port i with read_en[i]=1 in cycle T presents read_out[i] and read_valid[i] in cycle T+1.
  - When read_en[i]=0, read_valid[i]=0 next cycle and read_out[i] holds its previous value.
  - read_valid[i]=1 iff the addressed register is not pending after this cycle's write and before this cycle's reservation takes effect (see the optional feature for the same-cycle write case).
  - read_out carries the data regardless of read_valid; the consumer stalls when read_valid=0.
- Multiple ports may read the same address in the same cycle; each returns identical results.
- pend_cnt:
  - +1 per newly set bit, -1 per cleared bit; no change when a write and a grant to the same address cancel out.
  - Never exceeds 2**ADDR_W-1.

Optional Feature:
- Macro: LOCK_REGFILE_BYPASS_EN.
- Defined: a read in the same cycle as a write to the same nonzero address returns write_val next cycle, with read_valid=1 (the write clears pending first).
- Undefined: that read returns the old register contents, and read_valid reflects the pending bit before the write. The consumer must re-read a cycle later.
- res_ok and the reservation semantics are identical in both builds.

Test Plan:
- Reset then read: rst_n=0 mid-stream then 1; read_en=2'b11, addr 3 and 0 -> next cycle read_out = 0 and 0, read_valid=2'b11, pend_cnt=0.
- Write/read: write r5=0xDEADBEEF at T; read r5 on port 1 at T+1 -> at T+2 read_out[1]=0xDEADBEEF, valid=1.
- Lock: reserve r7 (res_ok=1) -> pend_cnt=1. Reserve r7 again -> res_ok=0. Read r7 -> valid=0. Write r7=0x12 -> pend_cnt=0. Next read r7 -> 0x12, valid=1.
- Same-cycle release+reserve: with r9 pending, write r9=0x44 and res r9 together -> res_ok=1, pending stays 1, pend_cnt unchanged, stored value 0x44.
- Bypass: r4=0x1 pending; write r4=0x2 and read r4 same cycle.
  - With LOCK_REGFILE_BYPASS_EN -> 0x2, valid=1.
  - Without -> 0x1, valid=0.
- Zero register: write r0=0xFFFF and reserve r0 -> res_ok=1, pend_cnt=0, read r0 -> 0, valid=1.
